// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Run controller for an iterating datapath. Turns start / stop /
//               step commands into a datapath enable (en) and synchronous
//               clear (rst). It counts enabled cycles (generations) and
//               finishes after a programmable limit.
//               Optional build macro RUN_CTRL_AUTO_RESTART_EN: DONE lasts one
//               cycle, then the controller re-enters CLEAR automatically.
// Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl #(
    parameter int CW         = 16,  // width of limit and gen_count
    parameter int CLR_CYCLES = 2    // cycles rst is held in CLEAR (1..255)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          step,
    input  logic [CW-1:0] limit,
    output logic          en,
    output logic          rst,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] gen_count,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_STEP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Last value of the clear counter before leaving CLEAR.
    localparam logic [7:0]    c_clr_last = 8'(CLR_CYCLES - 1);
    // Saturation ceiling of the generation counter.
    localparam logic [CW-1:0] c_gen_max  = {CW{1'b1}};

    state_t        r_state;
    state_t        w_state_next;
    logic [7:0]    r_clr_cnt;
    logic [7:0]    w_clr_cnt_next;
    logic [CW-1:0] r_limit;
    logic [CW-1:0] w_limit_next;
    logic [CW-1:0] r_gen_count;
    logic [CW-1:0] w_gen_next;

    logic [CW-1:0] w_gen_inc;
    logic [CW:0]   w_gen_plus1;
    logic          w_limit_hit;

    // Saturating increment; one extra bit for the limit compare so that
    // gen_count+1 never wraps into a false match.
    assign w_gen_inc   = (r_gen_count == c_gen_max) ? r_gen_count
                                                    : r_gen_count + {{(CW-1){1'b0}}, 1'b1};
    assign w_gen_plus1 = {1'b0, r_gen_count} + {{CW{1'b0}}, 1'b1};
    assign w_limit_hit = (r_limit != {CW{1'b0}}) && (w_gen_plus1 == {1'b0, r_limit});

    // State, clear counter, latched limit and generation counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_clr_cnt   <= 8'd0;
            r_limit     <= {CW{1'b0}};
            r_gen_count <= {CW{1'b0}};
        end else begin
            r_state     <= w_state_next;
            r_clr_cnt   <= w_clr_cnt_next;
            r_limit     <= w_limit_next;
            r_gen_count <= w_gen_next;
        end
    end

    // Next-state logic; every path into CLEAR zeroes gen_count and the
    // clear counter so the clear window always starts from a known point.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_limit_next   = r_limit;
        w_gen_next     = r_gen_count;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next   = S_CLEAR;
                    w_clr_cnt_next = 8'd0;
                    w_gen_next     = {CW{1'b0}};
                end else if (step) begin
                    w_state_next = S_STEP;
                end
            end

            S_CLEAR: begin
                if (stop) begin
                    w_state_next   = S_IDLE;
                    w_clr_cnt_next = 8'd0;
                end else if (r_clr_cnt == c_clr_last) begin
                    w_state_next   = S_RUN;
                    w_clr_cnt_next = 8'd0;
                    w_limit_next   = limit;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 8'd1;
                end
            end

            S_RUN: begin
                // Every RUN cycle is an enabled cycle, including the one
                // that leaves RUN, so the count always advances here.
                w_gen_next = w_gen_inc;
                if (w_limit_hit) begin
                    w_state_next = S_DONE;
                end else if (stop) begin
                    w_state_next = S_PAUSE;
                end
            end

            S_STEP: begin
                w_gen_next   = w_gen_inc;
                w_state_next = S_PAUSE;
            end

            S_PAUSE: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (start) begin
                    w_state_next = S_RUN;
                end else if (step) begin
                    w_state_next = S_STEP;
                end
            end

            S_DONE: begin
`ifdef RUN_CTRL_AUTO_RESTART_EN
                if (stop) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next   = S_CLEAR;
                    w_clr_cnt_next = 8'd0;
                    w_gen_next     = {CW{1'b0}};
                end
`else
                if (stop) begin
                    w_state_next = S_IDLE;
                end else if (start) begin
                    w_state_next   = S_CLEAR;
                    w_clr_cnt_next = 8'd0;
                    w_gen_next     = {CW{1'b0}};
                end
`endif
            end

            default: begin
                // Unused codes 6 and 7 recover to IDLE.
                w_state_next   = S_IDLE;
                w_clr_cnt_next = 8'd0;
            end
        endcase
    end

    // Moore output decode straight from the state register.
    assign en        = (r_state == S_RUN) || (r_state == S_STEP);
    assign rst       = (r_state == S_CLEAR);
    assign busy      = (r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_STEP);
    assign done      = (r_state == S_DONE);
    assign gen_count = r_gen_count;
    assign state_o   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_ctrl
// Description : Directed self-checking bench for run_ctrl. One instance uses
//               the default widths; a second instance with CW=4 covers
//               generation counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_ctrl;

    logic        clk;
    logic        r_reset;
    logic        r_start;
    logic        r_stop;
    logic        r_step;
    logic [15:0] r_limit;
    logic        w_en;
    logic        w_rst;
    logic        w_busy;
    logic        w_done;
    logic [15:0] w_gen;
    logic [2:0]  w_state;

    logic        r_start4;
    logic        r_stop4;
    logic        r_step4;
    logic [3:0]  r_limit4;
    logic        w_en4;
    logic        w_rst4;
    logic        w_busy4;
    logic        w_done4;
    logic [3:0]  w_gen4;
    logic [2:0]  w_state4;

    int n_tests = 0;
    int n_fail  = 0;

    run_ctrl #(.CW(16), .CLR_CYCLES(2)) u_dut (
        .clk       (clk),
        .reset     (r_reset),
        .start     (r_start),
        .stop      (r_stop),
        .step      (r_step),
        .limit     (r_limit),
        .en        (w_en),
        .rst       (w_rst),
        .busy      (w_busy),
        .done      (w_done),
        .gen_count (w_gen),
        .state_o   (w_state)
    );

    run_ctrl #(.CW(4), .CLR_CYCLES(2)) u_sat (
        .clk       (clk),
        .reset     (r_reset),
        .start     (r_start4),
        .stop      (r_stop4),
        .step      (r_step4),
        .limit     (r_limit4),
        .en        (w_en4),
        .rst       (w_rst4),
        .busy      (w_busy4),
        .done      (w_done4),
        .gen_count (w_gen4),
        .state_o   (w_state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

`ifdef RUN_CTRL_AUTO_RESTART_EN
    logic [2:0] pat [6];
`endif

    initial begin
        r_reset  = 1'b1;
        r_start  = 1'b0;
        r_stop   = 1'b0;
        r_step   = 1'b0;
        r_limit  = 16'd0;
        r_start4 = 1'b0;
        r_stop4  = 1'b0;
        r_step4  = 1'b0;
        r_limit4 = 4'd0;

        // Reset values
        nxt();
        nxt();
        chk("reset_state", 32'(w_state), 0);
        chk("reset_en",    32'(w_en),    0);
        chk("reset_rst",   32'(w_rst),   0);
        chk("reset_busy",  32'(w_busy),  0);
        chk("reset_done",  32'(w_done),  0);
        chk("reset_gen",   32'(w_gen),   0);
        r_reset = 1'b0;

        // Limited run of 5: rst x2, en x5, then DONE
        r_limit = 16'd5;
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        chk("t1_clr0_rst",   32'(w_rst),   1);
        chk("t1_clr0_state", 32'(w_state), 1);
        chk("t1_clr0_busy",  32'(w_busy),  1);
        chk("t1_clr0_en",    32'(w_en),    0);
        nxt();
        chk("t1_clr1_rst",   32'(w_rst),   1);
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("t1_run_en",  32'(w_en),  1);
            chk("t1_run_gen", 32'(w_gen), 32'(i));
        end
        nxt();
        chk("t1_done",       32'(w_done),  1);
        chk("t1_done_en",    32'(w_en),    0);
        chk("t1_done_gen",   32'(w_gen),   5);
        chk("t1_done_busy",  32'(w_busy),  0);
        chk("t1_done_state", 32'(w_state), 5);
        nxt();
`ifdef RUN_CTRL_AUTO_RESTART_EN
        chk("t1_autorestart_state", 32'(w_state), 1);
`else
        chk("t1_done_hold_state", 32'(w_state), 5);
        chk("t1_done_hold_gen",   32'(w_gen),   5);
`endif
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("t1_to_idle", 32'(w_state), 0);

        // stop alone in IDLE is ignored
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("idle_stop_ignored", 32'(w_state), 0);

        // Unlimited run of 20, stop -> PAUSE, resume without clear
        r_limit = 16'd0;
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        nxt();
        for (int i = 0; i < 20; i++) begin
            nxt();
            chk("t2_run_gen", 32'(w_gen), 32'(i));
            if (i == 19) r_stop = 1'b1;
        end
        nxt();
        r_stop = 1'b0;
        chk("t2_pause_state", 32'(w_state), 3);
        chk("t2_pause_en",    32'(w_en),    0);
        chk("t2_pause_gen",   32'(w_gen),   20);
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        chk("t2_resume_state", 32'(w_state), 2);
        chk("t2_resume_en",    32'(w_en),    1);
        chk("t2_resume_rst",   32'(w_rst),   0);
        chk("t2_resume_gen",   32'(w_gen),   20);
        nxt();
        chk("t2_resume_gen2", 32'(w_gen), 21);
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("t2_pause2_state", 32'(w_state), 3);
        chk("t2_pause2_gen",   32'(w_gen),   22);

        // Single step from PAUSE
        r_step = 1'b1;
        nxt();
        r_step = 1'b0;
        chk("step_state", 32'(w_state), 4);
        chk("step_en",    32'(w_en),    1);
        chk("step_gen",   32'(w_gen),   22);
        nxt();
        chk("step_back_state", 32'(w_state), 3);
        chk("step_back_en",    32'(w_en),    0);
        chk("step_back_gen",   32'(w_gen),   23);

        // step+start together in PAUSE: start wins
        r_step  = 1'b1;
        r_start = 1'b1;
        nxt();
        r_step  = 1'b0;
        r_start = 1'b0;
        chk("step_start_state", 32'(w_state), 2);
        chk("step_start_gen",   32'(w_gen),   23);
        r_stop = 1'b1;
        nxt();
        chk("run_stop_state", 32'(w_state), 3);
        chk("run_stop_gen",   32'(w_gen),   24);
        nxt();
        r_stop = 1'b0;
        chk("pause_stop_idle", 32'(w_state), 0);

        // step from IDLE
        r_step = 1'b1;
        nxt();
        r_step = 1'b0;
        chk("idle_step_state", 32'(w_state), 4);
        chk("idle_step_gen",   32'(w_gen),   24);
        nxt();
        chk("idle_step_pause", 32'(w_state), 3);
        chk("idle_step_gen2",  32'(w_gen),   25);
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("idle_step_idle", 32'(w_state), 0);

        // stop aborts CLEAR
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        chk("abort_clr_state", 32'(w_state), 1);
        chk("abort_clr_gen",   32'(w_gen),   0);
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("abort_idle_state", 32'(w_state), 0);
        chk("abort_idle_rst",   32'(w_rst),   0);

        // limit=4 with stop on the 4th enabled cycle: DONE wins
        r_limit = 16'd4;
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        nxt();
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("t3_run_gen", 32'(w_gen), 32'(i));
            if (i == 3) r_stop = 1'b1;
        end
        nxt();
        r_stop = 1'b0;
        chk("t3_done_state", 32'(w_state), 5);
        chk("t3_done",       32'(w_done),  1);
        chk("t3_done_gen",   32'(w_gen),   4);
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        chk("t3_restart_state", 32'(w_state), 1);
        chk("t3_restart_gen",   32'(w_gen),   0);
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("t3_idle", 32'(w_state), 0);

        // Asynchronous reset mid-RUN at gen_count=7
        r_limit = 16'd0;
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        nxt();
        for (int i = 0; i < 8; i++) nxt();
        chk("t4_pre_gen", 32'(w_gen), 7);
        #2 r_reset = 1'b1;
        #1;
        chk("t4_async_en",    32'(w_en),    0);
        chk("t4_async_gen",   32'(w_gen),   0);
        chk("t4_async_state", 32'(w_state), 0);
        chk("t4_async_busy",  32'(w_busy),  0);
        nxt();
        r_reset = 1'b0;

        // CW=4 saturation in an unlimited run
        r_start4 = 1'b1;
        nxt();
        r_start4 = 1'b0;
        nxt();
        for (int i = 0; i < 20; i++) begin
            nxt();
            chk("sat_gen", 32'(w_gen4), (i > 15) ? 32'd15 : 32'(i));
            chk("sat_en",  32'(w_en4),  1);
        end
        r_stop4 = 1'b1;
        nxt();
        r_stop4 = 1'b0;
        chk("sat_pause_gen", 32'(w_gen4), 15);

`ifdef RUN_CTRL_AUTO_RESTART_EN
        // Auto restart: CLEAR,CLEAR,RUN,RUN,RUN,DONE repeating
        pat[0] = 3'd1; pat[1] = 3'd1; pat[2] = 3'd2;
        pat[3] = 3'd2; pat[4] = 3'd2; pat[5] = 3'd5;
        r_limit = 16'd3;
        r_start = 1'b1;
        nxt();
        r_start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk("auto_state", 32'(w_state), 32'(pat[c % 6]));
            chk("auto_done",  32'(w_done),  (pat[c % 6] == 3'd5) ? 32'd1 : 32'd0);
            nxt();
        end
        r_stop = 1'b1;
        nxt();
        r_stop = 1'b0;
        chk("auto_stop_idle", 32'(w_state), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
